// File: rtl/timer_pkg.sv
// Shared register map constants, CTRL layout and channel state type for timer_multi.
package timer_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned PRE_MAX_W  = 8;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LOAD  = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_RSVD  = 2'd3;

    localparam logic [ADDR_W-1:0] IRQ_STATUS_OFS = 16'h0040;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_AUTO    = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_PRE_LSB = 8;

    typedef struct packed {
        logic [PRE_MAX_W-1:0] prescale;
        logic                 ie;
        logic                 auto_rl;
        logic                 en;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Bus view of a channel's CTRL register; unused bits read as zero.
    function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
        return {c.prescale, 5'b0, c.ie, c.auto_rl, c.en};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: prescaler, counter, IDLE/RUN mode and expiry pulse.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              ctrl_we,
    input  logic              load_we,
    input  logic              count_we,
    input  logic [DATA_W-1:0] wdata,
    output ctrl_t             ctrl_o,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] count_o,
    output logic              expire_c,
    output logic              event_o
);

    ch_state_e              state_q, state_d;
    logic                   auto_q, auto_d;
    logic                   ie_q, ie_d;
    logic [PRE_MAX_W-1:0]   pre_cfg_q, pre_cfg_d;
    logic [PRE_MAX_W-1:0]   presc_q, presc_d;
    logic [DATA_W-1:0]      load_q, load_d;
    logic [DATA_W-1:0]      count_q, count_d;
    logic                   event_q, event_d;
    logic                   tick;

    always_comb begin
        state_d   = state_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        pre_cfg_d = pre_cfg_q;
        presc_d   = presc_q;
        load_d    = load_q;
        count_d   = count_q;
        event_d   = 1'b0;

        tick     = (state_q == ST_RUN) && (presc_q == pre_cfg_q);
        expire_c = tick && (count_q == '0) && !count_we;

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : PRE_MAX_W'(presc_q + PRE_MAX_W'(1));
        end

        // A bus write to COUNT in the tick cycle suppresses both decrement and expiry.
        if (tick && !count_we) begin
            if (count_q != '0) begin
                count_d = DATA_W'(count_q - DATA_W'(1));
            end else begin
                event_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        if (count_we) begin
            count_d = wdata;
        end
        if (load_we) begin
            load_d = wdata;
        end

        // CTRL write overrides the expiry's EN update; prescaler restarts on enable.
        if (ctrl_we) begin
            state_d   = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
            auto_d    = wdata[CTRL_AUTO];
            ie_d      = wdata[CTRL_IE];
            pre_cfg_d = PRE_MAX_W'(wdata[CTRL_PRE_LSB +: PRESCALE_W]);
            if (wdata[CTRL_EN] && (state_q == ST_IDLE)) begin
                presc_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            pre_cfg_q <= '0;
            presc_q   <= '0;
            load_q    <= '0;
            count_q   <= '0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            pre_cfg_q <= pre_cfg_d;
            presc_q   <= presc_d;
            load_q    <= load_d;
            count_q   <= count_d;
            event_q   <= event_d;
        end
    end

    assign ctrl_o  = {pre_cfg_q, ie_q, auto_q, (state_q == ST_RUN)};
    assign load_o  = load_q;
    assign count_o = count_q;
    assign event_o = event_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer peripheral: bus decode, NUM_CH channels, W1C IRQ status, read mux.
module timer_multi
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h8200,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_strobe,
    output logic [NUM_CH-1:0] o_event,
    output logic              o_irq
);

    localparam logic [ADDR_W-1:0] CH_SPAN = ADDR_W'(4 * NUM_CH);

    logic [ADDR_W-1:0] wr_ofs, rd_ofs;
    logic [NUM_CH-1:0] ctrl_we, load_we, count_we;
    logic              irq_we;
    logic [NUM_CH-1:0] ie_next;
    logic [NUM_CH-1:0] ch_expire, ch_event;
    ctrl_t             ch_ctrl  [NUM_CH];
    logic [DATA_W-1:0] ch_load  [NUM_CH];
    logic [DATA_W-1:0] ch_count [NUM_CH];

    logic [NUM_CH-1:0] flag_q, flag_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign wr_ofs = ADDR_W'(write_addr - BASE_ADDR);
    assign rd_ofs = ADDR_W'(read_addr - BASE_ADDR);

    // Write decode; offsets past the last implemented channel are ignored.
    always_comb begin
        ctrl_we  = '0;
        load_we  = '0;
        count_we = '0;
        irq_we   = write_strobe && (wr_ofs == IRQ_STATUS_OFS);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (write_strobe && (wr_ofs < CH_SPAN) && (wr_ofs[4:2] == 3'(c))) begin
                ctrl_we[c]  = (wr_ofs[1:0] == REG_CTRL);
                load_we[c]  = (wr_ofs[1:0] == REG_LOAD);
                count_we[c] = (wr_ofs[1:0] == REG_COUNT);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        timer_channel #(
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .ctrl_we  (ctrl_we[c]),
            .load_we  (load_we[c]),
            .count_we (count_we[c]),
            .wdata    (write_data),
            .ctrl_o   (ch_ctrl[c]),
            .load_o   (ch_load[c]),
            .count_o  (ch_count[c]),
            .expire_c (ch_expire[c]),
            .event_o  (ch_event[c])
        );
    end

    // Flags: a new expiry beats a same-cycle write-1-to-clear; o_irq tracks next-state flags and IE.
    always_comb begin
        flag_d = flag_q & ~(irq_we ? write_data[NUM_CH-1:0] : '0);
        flag_d = flag_d | ch_expire;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ie_next[c] = ctrl_we[c] ? write_data[CTRL_IE] : ch_ctrl[c].ie;
        end
        irq_d = |(flag_d & ie_next);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_ofs < CH_SPAN) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (rd_ofs[4:2] == 3'(c)) begin
                    case (rd_ofs[1:0])
                        REG_CTRL:  rdata_d = ctrl_to_word(ch_ctrl[c]);
                        REG_LOAD:  rdata_d = ch_load[c];
                        REG_COUNT: rdata_d = ch_count[c];
                        default:   rdata_d = '0;
                    endcase
                end
            end
        end else if (rd_ofs == IRQ_STATUS_OFS) begin
            rdata_d = DATA_W'(flag_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flag_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            flag_q  <= flag_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_data = rdata_q;
    assign o_irq     = irq_q;
    assign o_event   = ch_event;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi (NUM_CH=2): register table plus timing/collision sequences.
module tb_timer_multi;

    logic        clk;
    logic        rst_n;
    logic [15:0] read_addr;
    logic [15:0] read_data;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_strobe;
    logic [1:0]  o_event;
    logic        o_irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    vec_t vecs[18];
    exp_t sb_q[$];

    timer_multi #(
        .BASE_ADDR  (16'h8200),
        .NUM_CH     (2),
        .PRESCALE_W (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_strobe (write_strobe),
        .o_event      (o_event),
        .o_irq        (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        write_addr   = a;
        write_data   = d;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
    endtask

    // Expected value queued at address launch, compared when registered data appears.
    task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string name);
        exp_t e;
        read_addr = a;
        sb_q.push_back('{exp: exp, name: name});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk16(e.name, read_data, e.exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        write_strobe = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [15:0] cnt_seq [9];
        logic [1:0]  ev_seq  [9];

        rst_n        = 1'b0;
        read_addr    = 16'h0000;
        write_addr   = 16'h0000;
        write_data   = 16'h0000;
        write_strobe = 1'b0;

        vecs[0]  = '{1'b1, 16'h8200, 16'hFFFE, 16'h0000, "ctrl0_wr"};
        vecs[1]  = '{1'b0, 16'h8200, 16'h0000, 16'hFF06, "ctrl0_rd"};
        vecs[2]  = '{1'b1, 16'h8201, 16'hBEEF, 16'h0000, "load0_wr"};
        vecs[3]  = '{1'b1, 16'h8202, 16'h1234, 16'h0000, "count0_wr"};
        vecs[4]  = '{1'b1, 16'h8203, 16'h5555, 16'h0000, "rsvd0_wr"};
        vecs[5]  = '{1'b1, 16'h8205, 16'hA5A5, 16'h0000, "load1_wr"};
        vecs[6]  = '{1'b1, 16'h8209, 16'h7777, 16'h0000, "ch2_load_wr"};
        vecs[7]  = '{1'b1, 16'h8208, 16'h0007, 16'h0000, "ch2_ctrl_wr"};
        vecs[8]  = '{1'b0, 16'h8201, 16'h0000, 16'hBEEF, "load0_rd"};
        vecs[9]  = '{1'b0, 16'h8202, 16'h0000, 16'h1234, "count0_rd"};
        vecs[10] = '{1'b0, 16'h8203, 16'h0000, 16'h0000, "rsvd0_rd"};
        vecs[11] = '{1'b0, 16'h8205, 16'h0000, 16'hA5A5, "load1_rd"};
        vecs[12] = '{1'b0, 16'h8206, 16'h0000, 16'h0000, "count1_rd"};
        vecs[13] = '{1'b0, 16'h8208, 16'h0000, 16'h0000, "ch2_ctrl_rd"};
        vecs[14] = '{1'b0, 16'h8209, 16'h0000, 16'h0000, "ch2_load_rd"};
        vecs[15] = '{1'b0, 16'h8240, 16'h0000, 16'h0000, "irq_status_rd"};
        vecs[16] = '{1'b0, 16'h81FC, 16'h0000, 16'h0000, "below_base_rd"};
        vecs[17] = '{1'b0, 16'h8241, 16'h0000, 16'h0000, "above_irq_rd"};

        cnt_seq = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
        ev_seq  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

        // Writes while held in reset must be ignored.
        cyc();
        wr(16'h8200, 16'h0007);
        wr(16'h8202, 16'h0000);
        rd_chk(16'h8200, 16'h0000, "rst_ctrl0_rd");
        chk16("rst_irq", 16'(o_irq), 16'h0);
        chk16("rst_event", 16'(o_event), 16'h0);
        rst_n = 1'b1;
        cyc();
        rd_chk(16'h8200, 16'h0000, "post_rst_ctrl0");
        rd_chk(16'h8202, 16'h0000, "post_rst_count0");

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else            rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Read latency is exactly one cycle: old data persists until the next edge.
        rd_chk(16'h8203, 16'h0000, "lat_prev_rd");
        read_addr = 16'h8201;
        #2;
        chk16("lat_no_zero_cycle", read_data, 16'h0000);
        @(posedge clk);
        #1;
        chk16("lat_one_cycle", read_data, 16'hBEEF);

        // Ch0 auto-reload, LOAD=3, PRESCALE=0.
        do_reset();
        wr(16'h8202, 16'd3);
        wr(16'h8201, 16'd3);
        wr(16'h8200, 16'h0003);
        for (int k = 0; k < 9; k++) begin
            exp_t e;
            read_addr = 16'h8202;
            sb_q.push_back('{exp: cnt_seq[k], name: "auto_count_seq"});
            cyc();
            e = sb_q.pop_front();
            chk16(e.name, read_data, e.exp);
            chk16("auto_event_seq", 16'(o_event), 16'(ev_seq[k]));
        end
        rd_chk(16'h8240, 16'h0001, "auto_flag_masked");
        chk16("auto_irq_masked", 16'(o_irq), 16'h0);

        // Ch1 one-shot, PRESCALE=2, COUNT=LOAD=1: expiry 6 cycles after enable.
        do_reset();
        wr(16'h8206, 16'd1);
        wr(16'h8205, 16'd1);
        wr(16'h8204, 16'h0205);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk16("oneshot_event", 16'(o_event), (k == 6) ? 16'h0002 : 16'h0000);
        end
        rd_chk(16'h8204, 16'h0204, "oneshot_en_cleared");
        rd_chk(16'h8206, 16'h0000, "oneshot_count_zero");
        rd_chk(16'h8240, 16'h0002, "oneshot_flag");
        chk16("oneshot_irq_set", 16'(o_irq), 16'h1);
        wr(16'h8240, 16'h0002);
        chk16("w1c_irq_clear", 16'(o_irq), 16'h0);
        rd_chk(16'h8240, 16'h0000, "w1c_flag_clear");

        // COUNT write lands on the expiry tick.
        do_reset();
        wr(16'h8201, 16'd3);
        wr(16'h8202, 16'd2);
        wr(16'h8200, 16'h0003);
        read_addr = 16'h8202;
        cyc();
        cyc();
        wr(16'h8202, 16'h0010);
        chk16("cnt_wr_no_event", 16'(o_event), 16'h0);
        rd_chk(16'h8202, 16'h0010, "cnt_wr_wins");
        rd_chk(16'h8240, 16'h0000, "cnt_wr_no_flag");

        // W1C lands on the expiry cycle.
        do_reset();
        wr(16'h8201, 16'd3);
        wr(16'h8202, 16'd2);
        wr(16'h8200, 16'h0007);
        cyc();
        cyc();
        wr(16'h8240, 16'h0001);
        chk16("w1c_coll_event", 16'(o_event), 16'h0001);
        chk16("w1c_coll_irq", 16'(o_irq), 16'h1);
        rd_chk(16'h8240, 16'h0001, "w1c_coll_flag");

        // CTRL write with EN=1 on a one-shot expiry keeps the channel running.
        do_reset();
        wr(16'h8206, 16'd0);
        wr(16'h8204, 16'h0001);
        wr(16'h8204, 16'h0001);
        chk16("ctrl_coll_event", 16'(o_event), 16'h0002);
        rd_chk(16'h8204, 16'h0001, "ctrl_coll_en_kept");

        // Asynchronous reset mid-count.
        do_reset();
        wr(16'h8202, 16'h1234);
        wr(16'h8200, 16'h0001);
        read_addr = 16'h8202;
        repeat (3) cyc();
        chk16("pre_rst_count", read_data, 16'h1232);
        #2;
        rst_n = 1'b0;
        #1;
        chk16("async_rst_rdata", read_data, 16'h0000);
        chk16("async_rst_event", 16'(o_event), 16'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        rd_chk(16'h8202, 16'h0000, "async_rst_count");
        rd_chk(16'h8200, 16'h0000, "async_rst_ctrl");
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk16("async_rst_no_event", 16'(o_event), 16'h0);
        end
        chk16("async_rst_no_irq", 16'(o_irq), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
